// File: rtl/dmem_responder.sv
// Data-memory responder for the RV64 memory stage.
// Accepts one load/store per handshake, waits LATENCY cycles, then performs
// the access against a byte-lane doubleword RAM and returns the result on a
// valid/ready response channel. Loads are sign- or zero-extended.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [ADDR_W-1:0]  r_addr;
  logic [63:0]        r_wdata;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [63:0]        r_resp_rdata;
  logic               r_resp_err;

  wire  [63:0]        w_rd_data;
  logic               w_accept;
  logic               w_commit;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_illegal;
  logic               w_err;
  logic               w_sx;
  logic [2:0]         w_lane;
  logic [5:0]         w_shift;
  logic [7:0]         w_size_mask;
  logic [7:0]         w_byte_en;
  logic [63:0]        w_wr_data;
  logic [63:0]        w_aligned;
  logic [63:0]        w_load_data;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wr_idx;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // The RAM read is launched on the accept edge so the word is ready by the
  // time the wait count expires; the write (if any) lands on that same
  // expiry edge, and never while reset is asserted.
  assign w_accept = req_valid && r_req_ready && (r_state == S_IDLE);
  assign w_commit = rst && (r_state == S_WAIT) && (r_cnt == '0);
  assign w_rd_idx = req_addr[IDX_W+2:3];
  assign w_wr_idx = r_addr[IDX_W+2:3];

  // Decode size, lane, error conditions and the extended load result
  always_comb begin
    w_lane  = r_addr[2:0];
    w_shift = {w_lane, 3'b000};
    w_sx    = !r_funct3[2];
    case (r_funct3[1:0])
      2'd0:    begin w_size_mask = 8'h01; w_misaligned = 1'b0;          end
      2'd1:    begin w_size_mask = 8'h03; w_misaligned = r_addr[0];     end
      2'd2:    begin w_size_mask = 8'h0F; w_misaligned = |r_addr[1:0]; end
      default: begin w_size_mask = 8'hFF; w_misaligned = |r_addr[2:0]; end
    endcase
    w_out_of_range = 64'(r_addr[ADDR_W-1:3]) >= 64'(DEPTH);
    w_illegal      = r_we ? r_funct3[2] : (r_funct3 == 3'b111);
    w_err          = w_misaligned || w_out_of_range || w_illegal;
    w_byte_en      = w_size_mask << w_lane;
    w_wr_data      = r_wdata << w_shift;
    w_aligned      = w_rd_data >> w_shift;
    case (r_funct3[1:0])
      2'd0:    w_load_data = {{56{w_sx & w_aligned[7]}},  w_aligned[7:0]};
      2'd1:    w_load_data = {{48{w_sx & w_aligned[15]}}, w_aligned[15:0]};
      2'd2:    w_load_data = {{32{w_sx & w_aligned[31]}}, w_aligned[31:0]};
      default: w_load_data = w_aligned;
    endcase
    if (w_err || r_we) begin
      w_load_data = '0;
    end
  end

  // One RAM per byte lane so a store only touches the lanes it covers
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_byte;

    // Masked lane write on commit, registered lane read on accept
    always_ff @(posedge clk) begin
      if (w_commit && !w_err && r_we && w_byte_en[gi]) begin
        r_mem[w_wr_idx] <= w_wr_data[gi*8 +: 8];
      end
      if (w_accept) begin
        r_rd_byte <= r_mem[w_rd_idx];
      end
    end

    assign w_rd_data[gi*8 +: 8] = r_rd_byte;
  end

  // Request/response sequencing: IDLE accepts, WAIT counts down, RESP holds
  // the result until the initiator takes it. A LATENCY of 1 spends a single
  // cycle in WAIT with the count already at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= CNT_W'(LATENCY - 1);
            r_state     <= S_WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load_data;
            r_resp_err   <= w_err;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
